clk_div_multi: RTL

Parametrised multi-channel programmable clock divider, the next generation of the fixed-divisor divider. It produces NUM_CH independent divided clocks from one input clock. Each channel has a runtime-loadable divisor and high-time, a per-channel enable, and a one-cycle period strobe. It feeds the VGA pixel/timing logic and any slow blink/debounce domains. Divisor changes take effect only at period boundaries, so the outputs never glitch.

---
 rtl/clk_div_multi.sv | 109 ++++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with shadowed divisor/high-time settings.
// New settings are applied only at period boundaries (or while disabled), so outputs never glitch.
module clk_div_multi #(
  parameter int WIDTH       = 28,
  parameter int NUM_CH      = 2,
  parameter int DEFAULT_DIV = 5
) (
  input  logic                    clock_in,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] div_in,
  input  logic [NUM_CH*WIDTH-1:0] high_in,
  output logic [NUM_CH-1:0]       clock_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       div_err
);

  localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_HIGH = WIDTH'(DEFAULT_DIV / 2);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] high_act;
    logic [WIDTH-1:0] div_sh;
    logic [WIDTH-1:0] high_sh;
    logic [WIDTH-1:0] div_req;
    logic [WIDTH-1:0] high_req;
    logic [WIDTH-1:0] high_norm;
    logic             pend;
    logic             load_ok;
    logic             boundary;
    logic             clk_q;
    logic             tick_q;
    logic             err_q;

    assign div_req  = div_in[ch*WIDTH +: WIDTH];
    assign high_req = high_in[ch*WIDTH +: WIDTH];
    assign load_ok  = load[ch] && (div_req >= WIDTH'(2));
    assign boundary = (cnt == div_act - WIDTH'(1));

    // A zero high time means "use 50%"; anything that would leave no low cycle is clamped.
    always_comb begin
      high_norm = high_req;
      if (high_req == '0)
        high_norm = div_req >> 1;
      else if (high_req >= div_req)
        high_norm = div_req - WIDTH'(1);
    end

    always_ff @(posedge clock_in or negedge rst_n) begin
      if (!rst_n) begin
        cnt      <= '0;
        div_act  <= DEF_DIV;
        high_act <= DEF_HIGH;
        div_sh   <= DEF_DIV;
        high_sh  <= DEF_HIGH;
        pend     <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        if (load[ch])
          err_q <= !load_ok;
        if (load_ok) begin
          div_sh  <= div_req;
          high_sh <= high_norm;
        end

        if (!enable[ch]) begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
          // Idle channel has no period to protect, so settings go live at once.
          if (load_ok) begin
            div_act  <= div_req;
            high_act <= high_norm;
            pend     <= 1'b0;
          end else if (pend) begin
            div_act  <= div_sh;
            high_act <= high_sh;
            pend     <= 1'b0;
          end
        end else begin
          cnt    <= boundary ? '0 : cnt + WIDTH'(1);
          clk_q  <= (cnt < high_act);
          tick_q <= (cnt == '0);
          if (boundary && load_ok) begin
            div_act  <= div_req;
            high_act <= high_norm;
            pend     <= 1'b0;
          end else if (boundary && pend) begin
            div_act  <= div_sh;
            high_act <= high_sh;
            pend     <= 1'b0;
          end else if (load_ok) begin
            pend <= 1'b1;
          end
        end
      end
    end

    assign clock_out[ch] = clk_q;
    assign tick[ch]      = tick_q;
    assign div_err[ch]   = err_q;
  end

endmodule
